jpeg_stream_writer: RTL and testbench

Encoder-side JFIF byte-stream assembler; produces the marker structure that `jpeg_fsm` parses. On `start` it emits SOI, one DQT segment holding two quantisation tables, SOF0, one DHT segment and SOS. It then passes entropy-coded bytes through, inserting 0x00 after every 0xFF, and finishes with EOI. It sits between the quant/Huffman table stores plus the entropy coder, and the byte-wide output port.

---
 rtl/jpeg_stream_writer_pkg.sv | 43 ++++
 rtl/jpeg_out_slot.sv | 52 +++++
 rtl/jpeg_stream_writer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_jpeg_stream_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_stream_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_stream_writer_pkg
//  Description : Shared writer state encodings, JFIF marker codes and the
//                header-segment sequencing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpeg_stream_writer_pkg;

  typedef logic [3:0] wr_state_t;

  localparam wr_state_t wr_state_idle = 4'd0;
  localparam wr_state_t wr_state_soi  = 4'd1;
  localparam wr_state_t wr_state_dqt  = 4'd2;
  localparam wr_state_t wr_state_sof  = 4'd3;
  localparam wr_state_t wr_state_dht  = 4'd4;
  localparam wr_state_t wr_state_sos  = 4'd5;
  localparam wr_state_t wr_state_ent  = 4'd6;
  localparam wr_state_t wr_state_stuf = 4'd7;
  localparam wr_state_t wr_state_eoi  = 4'd8;

  // Second byte of each marker; every marker is preceded by mk_prefix.
  localparam logic [7:0] mk_prefix = 8'hFF;
  localparam logic [7:0] mk_soi    = 8'hD8;
  localparam logic [7:0] mk_dqt    = 8'hDB;
  localparam logic [7:0] mk_sof0   = 8'hC0;
  localparam logic [7:0] mk_dht    = 8'hC4;
  localparam logic [7:0] mk_sos    = 8'hDA;
  localparam logic [7:0] mk_eoi    = 8'hD9;

  // Header segments are emitted in a fixed order; SOS hands over to entropy.
  function automatic wr_state_t wr_next_hdr(input wr_state_t s);
    case (s)
      wr_state_soi: return wr_state_dqt;
      wr_state_dqt: return wr_state_sof;
      wr_state_sof: return wr_state_dht;
      wr_state_dht: return wr_state_sos;
      default:      return wr_state_ent;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_out_slot
//  Description : One-entry valid/ready output register. It may be reloaded
//                in the same cycle it is drained; data holds while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         can_load
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign can_load  = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load wins over drain so a drained slot refills without a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jpeg_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_stream_writer
//  Description : JFIF byte-stream assembler: SOI, DQT, SOF0, DHT, SOS,
//                byte-stuffed entropy data, EOI.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_stream_writer
  import jpeg_stream_writer_pkg::*;
#(
  parameter int HT_BYTES = 416
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pic_is_411,
  input  logic [15:0] width,
  input  logic [15:0] heigth,
  output logic [6:0]  qt_addr,
  input  logic [7:0]  qt_data,
  output logic [8:0]  ht_addr,
  input  logic [7:0]  ht_data,
  input  logic        ent_valid,
  input  logic [7:0]  ent_data,
  input  logic        ent_last,
  output logic        ent_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        pic_done
);

  localparam logic [15:0] HT_LEN   = 16'(HT_BYTES + 2);
  localparam logic [9:0]  DHT_LAST = 10'(HT_BYTES + 3);

  wr_state_t   state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [6:0]  qt_addr_q, qt_addr_d;
  logic [8:0]  ht_addr_q, ht_addr_d;
  logic        data_ok_q, data_ok_d;
  logic        busy_q, busy_d;
  logic        pic_done_q, pic_done_d;
  logic        last_q, last_d;
  logic        s411_q, s411_d;
  logic [15:0] width_q, width_d;
  logic [15:0] heigth_q, heigth_d;

  logic        can_load, load, byte_avail, seg_last, qt_tbl, ht_tbl;
  logic [7:0]  byte_val;

  assign qt_addr  = qt_addr_q;
  assign ht_addr  = ht_addr_q;
  assign busy     = busy_q;
  assign pic_done = pic_done_q;

  jpeg_out_slot #(.W(8)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (byte_val),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .can_load  (can_load)
  );

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= wr_state_idle;
      cnt_q      <= '0;
      qt_addr_q  <= '0;
      ht_addr_q  <= '0;
      data_ok_q  <= 1'b0;
      busy_q     <= 1'b0;
      pic_done_q <= 1'b0;
      last_q     <= 1'b0;
      s411_q     <= 1'b0;
      width_q    <= '0;
      heigth_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qt_addr_q  <= qt_addr_d;
      ht_addr_q  <= ht_addr_d;
      data_ok_q  <= data_ok_d;
      busy_q     <= busy_d;
      pic_done_q <= pic_done_d;
      last_q     <= last_d;
      s411_q     <= s411_d;
      width_q    <= width_d;
      heigth_q   <= heigth_d;
    end
  end

  // Output byte selection: constant bytes from (state, counter), table bytes
  // once the ROM data for the held address is valid, entropy passthrough.
  always_comb begin
    byte_val   = 8'h00;
    byte_avail = 1'b0;
    seg_last   = 1'b0;
    qt_tbl     = 1'b0;
    ht_tbl     = 1'b0;
    case (state_q)
      wr_state_soi: begin
        byte_avail = 1'b1;
        seg_last   = (cnt_q == 10'd1);
        byte_val   = (cnt_q == 10'd0) ? mk_prefix : mk_soi;
      end
      wr_state_dqt: begin
        seg_last = (cnt_q == 10'd133);
        if ((cnt_q >= 10'd5 && cnt_q <= 10'd68) || cnt_q >= 10'd70) begin
          qt_tbl     = 1'b1;
          byte_avail = data_ok_q;
          byte_val   = qt_data;
        end else begin
          byte_avail = 1'b1;
          case (cnt_q)
            10'd0:   byte_val = mk_prefix;
            10'd1:   byte_val = mk_dqt;
            10'd3:   byte_val = 8'h84;
            10'd69:  byte_val = 8'h01;
            default: byte_val = 8'h00;
          endcase
        end
      end
      wr_state_sof: begin
        byte_avail = 1'b1;
        seg_last   = (cnt_q == 10'd18);
        case (cnt_q)
          10'd0:   byte_val = mk_prefix;
          10'd1:   byte_val = mk_sof0;
          10'd3:   byte_val = 8'h11;
          10'd4:   byte_val = 8'h08;
          10'd5:   byte_val = heigth_q[15:8];
          10'd6:   byte_val = heigth_q[7:0];
          10'd7:   byte_val = width_q[15:8];
          10'd8:   byte_val = width_q[7:0];
          10'd9:   byte_val = 8'h03;
          10'd10:  byte_val = 8'h01;
          10'd11:  byte_val = s411_q ? 8'h22 : 8'h11;
          10'd13:  byte_val = 8'h02;
          10'd14:  byte_val = 8'h11;
          10'd15:  byte_val = 8'h01;
          10'd16:  byte_val = 8'h03;
          10'd17:  byte_val = 8'h11;
          10'd18:  byte_val = 8'h01;
          default: byte_val = 8'h00;
        endcase
      end
      wr_state_dht: begin
        seg_last = (cnt_q == DHT_LAST);
        if (cnt_q >= 10'd4) begin
          ht_tbl     = 1'b1;
          byte_avail = data_ok_q;
          byte_val   = ht_data;
        end else begin
          byte_avail = 1'b1;
          case (cnt_q)
            10'd0:   byte_val = mk_prefix;
            10'd1:   byte_val = mk_dht;
            10'd2:   byte_val = HT_LEN[15:8];
            default: byte_val = HT_LEN[7:0];
          endcase
        end
      end
      wr_state_sos: begin
        byte_avail = 1'b1;
        seg_last   = (cnt_q == 10'd13);
        case (cnt_q)
          10'd0:   byte_val = mk_prefix;
          10'd1:   byte_val = mk_sos;
          10'd3:   byte_val = 8'h0C;
          10'd4:   byte_val = 8'h03;
          10'd5:   byte_val = 8'h01;
          10'd7:   byte_val = 8'h02;
          10'd8:   byte_val = 8'h11;
          10'd9:   byte_val = 8'h03;
          10'd10:  byte_val = 8'h11;
          10'd12:  byte_val = 8'h3F;
          default: byte_val = 8'h00;
        endcase
      end
      wr_state_ent: begin
        byte_avail = ent_valid;
        byte_val   = ent_data;
      end
      wr_state_stuf: begin
        byte_avail = 1'b1;
        byte_val   = 8'h00;
      end
      wr_state_eoi: begin
        byte_avail = 1'b1;
        seg_last   = (cnt_q == 10'd1);
        byte_val   = (cnt_q == 10'd0) ? mk_prefix : mk_eoi;
      end
      default: ;
    endcase
    load      = byte_avail & can_load;
    ent_ready = (state_q == wr_state_ent) & can_load;
  end

  // Next-state, counter and table address sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qt_addr_d  = qt_addr_q;
    ht_addr_d  = ht_addr_q;
    busy_d     = busy_q;
    pic_done_d = 1'b0;
    last_d     = last_q;
    s411_d     = s411_q;
    width_d    = width_q;
    heigth_d   = heigth_q;
    case (state_q)
      wr_state_idle: begin
        if (start) begin
          state_d  = wr_state_soi;
          busy_d   = 1'b1;
          s411_d   = pic_is_411;
          width_d  = width;
          heigth_d = heigth;
        end
      end
      wr_state_soi, wr_state_dqt, wr_state_sof, wr_state_dht, wr_state_sos: begin
        if (load) begin
          if (seg_last) state_d = wr_next_hdr(state_q);
          else          cnt_d   = cnt_q + 10'd1;
        end
      end
      wr_state_ent: begin
        if (load) begin
          last_d = ent_last;
          if (ent_data == 8'hFF) state_d = wr_state_stuf;
          else if (ent_last)     state_d = wr_state_eoi;
        end
      end
      wr_state_stuf: begin
        if (load) state_d = last_q ? wr_state_eoi : wr_state_ent;
      end
      wr_state_eoi: begin
        if (load) begin
          if (seg_last) begin
            state_d    = wr_state_idle;
            busy_d     = 1'b0;
            pic_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = wr_state_idle;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Table addresses advance per consumed byte; the DHT address returns to
    // zero after its last byte, the quant address wraps naturally at 128.
    if (load && qt_tbl) qt_addr_d = qt_addr_q + 7'd1;
    if (load && ht_tbl) ht_addr_d = seg_last ? 9'd0 : ht_addr_q + 9'd1;
    // ROM data is trusted only after the address has been stable a cycle.
    data_ok_d = (qt_addr_d == qt_addr_q) && (ht_addr_d == ht_addr_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_stream_writer
//  Description : Scoreboard bench for jpeg_stream_writer: expected JFIF
//                streams are queued per picture, a monitor checks every
//                output handshake and stall stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_stream_writer;

  logic        clk = 1'b0;
  logic        rst, start, pic_is_411;
  logic [15:0] width, heigth;
  logic [6:0]  qt_addr;
  logic [7:0]  qt_data;
  logic [8:0]  ht_addr;
  logic [7:0]  ht_data;
  logic        ent_valid, ent_last, ent_ready;
  logic [7:0]  ent_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        busy, pic_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  bit          rdy_rand = 1'b0;
  logic [7:0]  exp_q[$];
  bit          hold_pending = 1'b0;
  logic [7:0]  hold_data;

  always #5 clk = ~clk;

  jpeg_stream_writer #(.HT_BYTES(416)) dut (
    .clk(clk), .rst(rst), .start(start), .pic_is_411(pic_is_411),
    .width(width), .heigth(heigth),
    .qt_addr(qt_addr), .qt_data(qt_data), .ht_addr(ht_addr), .ht_data(ht_data),
    .ent_valid(ent_valid), .ent_data(ent_data), .ent_last(ent_last), .ent_ready(ent_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .pic_done(pic_done)
  );

  function automatic logic [7:0] qt_rom(input int a);
    return 8'((a ^ 'h5A) & 255);
  endfunction

  function automatic logic [7:0] ht_rom(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Synchronous table ROMs: data follows the address by one clock.
  always @(posedge clk) begin
    qt_data <= qt_rom(int'(qt_addr));
    ht_data <= ht_rom(int'(ht_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare each accepted byte with the scoreboard, and require
  // a stalled byte to stay put until taken.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, hold_data});
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        else                   check("stream_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (pic_done) done_cnt++;
  end

  // Random backpressure when enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Reference header built segment by segment from the JFIF layout.
  task automatic push_header(input logic [15:0] w, input logic [15:0] h, input bit s411);
    int hl;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hD8);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hDB);
    exp_q.push_back(8'h00); exp_q.push_back(8'h84);
    for (int t = 0; t < 2; t++) begin
      exp_q.push_back(8'(t));
      for (int i = 0; i < 64; i++) exp_q.push_back(qt_rom(t * 64 + i));
    end
    exp_q.push_back(8'hFF); exp_q.push_back(8'hC0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h11); exp_q.push_back(8'h08);
    exp_q.push_back(h[15:8]); exp_q.push_back(h[7:0]);
    exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h01); exp_q.push_back(s411 ? 8'h22 : 8'h11); exp_q.push_back(8'h00);
    exp_q.push_back(8'h02); exp_q.push_back(8'h11); exp_q.push_back(8'h01);
    exp_q.push_back(8'h03); exp_q.push_back(8'h11); exp_q.push_back(8'h01);
    hl = 416 + 2;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hC4);
    exp_q.push_back(8'(hl / 256)); exp_q.push_back(8'(hl % 256));
    for (int i = 0; i < 416; i++) exp_q.push_back(ht_rom(i));
    exp_q.push_back(8'hFF); exp_q.push_back(8'hDA); exp_q.push_back(8'h00);
    exp_q.push_back(8'h0C); exp_q.push_back(8'h03);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_q.push_back(8'h02); exp_q.push_back(8'h11);
    exp_q.push_back(8'h03); exp_q.push_back(8'h11);
    exp_q.push_back(8'h00); exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Pulse start from idle and check busy and first-byte latency.
  task automatic start_picture(input logic [15:0] w, input logic [15:0] h, input bit s411);
    width = w; heigth = h; pic_is_411 = s411; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("first_byte", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hFF});
    tick();
  endtask

  task automatic send_ent(input logic [7:0] b, input bit last);
    bit acc;
    int guard;
    repeat ($urandom_range(0, 2)) tick();
    ent_valid = 1'b1; ent_data = b; ent_last = last;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 5000) begin
      @(negedge clk);
      acc = ent_ready;
      tick();
      guard++;
    end
    if (!acc) check("ent_accept_timeout", 32'd0, 32'd1);
    ent_valid = 1'b0; ent_last = 1'b0;
    ent_data = 8'($urandom);
  endtask

  task automatic run_picture(input logic [15:0] w, input logic [15:0] h, input bit s411,
                             input bit fixed_ent, input int n_ent, input bit poke);
    logic [7:0] ent[$];
    int d0, guard;
    if (fixed_ent) begin
      ent.push_back(8'h12); ent.push_back(8'hFF); ent.push_back(8'h34);
    end else begin
      for (int i = 0; i < n_ent; i++)
        ent.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
    end
    push_header(w, h, s411);
    foreach (ent[i]) begin
      exp_q.push_back(ent[i]);
      if (ent[i] == 8'hFF) exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'hFF); exp_q.push_back(8'hD9);
    d0 = done_cnt;
    start_picture(w, h, s411);
    foreach (ent[k]) begin
      if (poke && k == ent.size() / 2) begin
        start = 1'b1; tick(); start = 1'b0;
      end
      send_ent(ent[k], k == ent.size() - 1);
    end
    guard = 0;
    while ((done_cnt == d0 || exp_q.size() != 0) && guard < 5000) begin
      tick(); guard++;
    end
    repeat (10) tick();
    check("pic_done_count", done_cnt - d0, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
    check("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; pic_is_411 = 1'b0; width = '0; heigth = '0;
    ent_valid = 1'b0; ent_data = '0; ent_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data}, 32'd0);
    check("rst_ent_ready", {31'd0, ent_ready}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_pic_done",  {31'd0, pic_done}, 32'd0);
    check("rst_qt_addr",   {25'd0, qt_addr}, 32'd0);
    check("rst_ht_addr",   {23'd0, ht_addr}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // 640x480 4:1:1, free-running sink, then the same under backpressure.
    run_picture(16'd640, 16'd480, 1'b1, 1'b1, 0, 1'b0);
    rdy_rand = 1'b1;
    run_picture(16'd640, 16'd480, 1'b1, 1'b1, 0, 1'b0);

    // Random pictures; one gets a start pulse during entropy data.
    run_picture(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1, 1'b0);
    run_picture(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 30, 1'b1);
    rdy_rand = 1'b0;
    run_picture(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 25, 1'b0);

    // Reset in the middle of DHT, then a clean picture.
    rdy_rand = 1'b1;
    push_header(16'd64, 16'd48, 1'b0);
    start_picture(16'd64, 16'd48, 1'b0);
    guard = 0;
    while (ht_addr <= 9'd10 && guard < 5000) begin
      @(negedge clk); guard++;
    end
    check("reached_dht", {31'd0, ht_addr > 9'd10}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy",      {31'd0, busy}, 32'd0);
    check("midrst_ht_addr",   {23'd0, ht_addr}, 32'd0);
    check("midrst_ent_ready", {31'd0, ent_ready}, 32'd0);
    repeat (3) tick();
    run_picture(16'd320, 16'd240, 1'b0, 1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, actual timeout required finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
